// File: rtl/cortez_wb_pkg.sv
// Shared types and constants for the CORTEZ Wishbone command path.
package cortez_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } wb_state_e;

    typedef enum logic [1:0] {
        RSP_OK      = 2'b00,
        RSP_BUS_ERR = 2'b01,
        RSP_TIMEOUT = 2'b10
    } rsp_status_e;

    // Same window the bridge uses as its AXI4-Lite CSR base.
    localparam logic [31:0] CSR_BASE_ADDR = 32'h3000_0000;

endpackage

// File: rtl/wb_timeout_counter.sv
// Counts cycles with CYC high; flags the cycle that reaches the limit.
module wb_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic CLK,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] TC_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!rstn) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This cycle's increment would bring the count to TIMEOUT_CYCLES.
    assign tc = en && !clr && (cnt_q == TC_LAST);

endmodule

// File: rtl/wb_cmd_initiator.sv
// Single-outstanding Wishbone pipelined initiator driven by a
// valid/ready command stream, returning data and completion status.
module wb_cmd_initiator
    import cortez_wb_pkg::*;
#(
    parameter int unsigned OFFSET_WIDTH   = 16,
    parameter logic [31:0] BASE_ADDR      = CSR_BASE_ADDR,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                    CLK,
    input  logic                    rstn,
    input  logic                    CMD_VALID,
    output logic                    CMD_READY,
    input  logic                    CMD_WE,
    input  logic [OFFSET_WIDTH-1:0] CMD_ADDR,
    input  logic [7:0]              CMD_WDATA,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [7:0]              RSP_RDATA,
    output logic [1:0]              RSP_STATUS,
    output logic                    BUSY,
    output logic                    CYC,
    output logic                    STB,
    output logic                    WE,
    output logic                    SEL,
    output logic [31:0]             ADDR,
    output logic [7:0]              WDATA,
    input  logic                    STALL,
    input  logic                    ACK,
    input  logic                    ERR,
    input  logic [7:0]              RDATA
);

    wb_state_e   state_q, state_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic        we_q, we_d;
    logic        sel_q, sel_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [7:0]  rsp_rdata_q, rsp_rdata_d;
    logic [1:0]  rsp_status_q, rsp_status_d;
    logic        busy_q, busy_d;

    logic        tmo_hit;
    logic        tmo_clr;
    logic        bus_done;
    logic        finish;
    logic [1:0]  fin_status;
    logic [7:0]  fin_rdata;

    assign tmo_clr = !cyc_q;

    wb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .CLK (CLK),
        .rstn(rstn),
        .clr (tmo_clr),
        .en  (cyc_q),
        .tc  (tmo_hit)
    );

    // A bus answer in the limit cycle beats the timeout; ERR beats ACK.
    always_comb begin
        bus_done = 1'b0;
        unique case (state_q)
            ST_REQ:  bus_done = !STALL && (ACK || ERR);
            ST_WAIT: bus_done = ACK || ERR;
            default: bus_done = 1'b0;
        endcase
        finish     = bus_done || tmo_hit;
        fin_status = RSP_TIMEOUT;
        fin_rdata  = 8'h00;
        if (bus_done) begin
            fin_status = ERR ? RSP_BUS_ERR : RSP_OK;
            fin_rdata  = (!ERR && !we_q) ? RDATA : 8'h00;
        end
    end

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_status_d = rsp_status_q;
        unique case (state_q)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    state_d = ST_REQ;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    sel_d   = 1'b1;
                    we_d    = CMD_WE;
                    addr_d  = BASE_ADDR + 32'(CMD_ADDR);
                    wdata_d = CMD_WDATA;
                end
            end
            ST_REQ, ST_WAIT: begin
                if (finish) begin
                    state_d      = ST_RESP;
                    cyc_d        = 1'b0;
                    stb_d        = 1'b0;
                    sel_d        = 1'b0;
                    we_d         = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_status_d = fin_status;
                    rsp_rdata_d  = fin_rdata;
                end else if (state_q == ST_REQ && !STALL) begin
                    state_d = ST_WAIT;
                    stb_d   = 1'b0;
                end
            end
            ST_RESP: begin
                if (RSP_READY) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            sel_q        <= 1'b0;
            addr_q       <= 32'h0;
            wdata_q      <= 8'h00;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 8'h00;
            rsp_status_q <= 2'b00;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            stb_q        <= stb_d;
            we_q         <= we_d;
            sel_q        <= sel_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
            busy_q       <= busy_d;
        end
    end

    // Held low while reset is asserted so no command slips in.
    assign CMD_READY  = rstn && (state_q == ST_IDLE);
    assign RSP_VALID  = rsp_valid_q;
    assign RSP_RDATA  = rsp_rdata_q;
    assign RSP_STATUS = rsp_status_q;
    assign BUSY       = busy_q;
    assign CYC        = cyc_q;
    assign STB        = stb_q;
    assign WE         = we_q;
    assign SEL        = sel_q;
    assign ADDR       = addr_q;
    assign WDATA      = wdata_q;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Directed bench for wb_cmd_initiator with a short timeout limit.
module tb_wb_cmd_initiator;

    logic        CLK;
    logic        rstn;
    logic        CMD_VALID;
    logic        CMD_READY;
    logic        CMD_WE;
    logic [15:0] CMD_ADDR;
    logic [7:0]  CMD_WDATA;
    logic        RSP_VALID;
    logic        RSP_READY;
    logic [7:0]  RSP_RDATA;
    logic [1:0]  RSP_STATUS;
    logic        BUSY;
    logic        CYC;
    logic        STB;
    logic        WE;
    logic        SEL;
    logic [31:0] ADDR;
    logic [7:0]  WDATA;
    logic        STALL;
    logic        ACK;
    logic        ERR;
    logic [7:0]  RDATA;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc_cnt;

    wb_cmd_initiator #(
        .OFFSET_WIDTH  (16),
        .BASE_ADDR     (32'h3000_0000),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK       (CLK),
        .rstn      (rstn),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_WE    (CMD_WE),
        .CMD_ADDR  (CMD_ADDR),
        .CMD_WDATA (CMD_WDATA),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_RDATA (RSP_RDATA),
        .RSP_STATUS(RSP_STATUS),
        .BUSY      (BUSY),
        .CYC       (CYC),
        .STB       (STB),
        .WE        (WE),
        .SEL       (SEL),
        .ADDR      (ADDR),
        .WDATA     (WDATA),
        .STALL     (STALL),
        .ACK       (ACK),
        .ERR       (ERR),
        .RDATA     (RDATA)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic we, input logic [15:0] a,
                            input logic [7:0] d);
        CMD_VALID = 1'b1;
        CMD_WE    = we;
        CMD_ADDR  = a;
        CMD_WDATA = d;
        tick();
        CMD_VALID = 1'b0;
    endtask

    task automatic rsp_take();
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
    endtask

    initial begin
        rstn = 1'b0;
        CMD_VALID = 1'b0;
        CMD_WE = 1'b0;
        CMD_ADDR = 16'h0;
        CMD_WDATA = 8'h0;
        RSP_READY = 1'b0;
        STALL = 1'b0;
        ACK = 1'b0;
        ERR = 1'b0;
        RDATA = 8'h00;
        repeat (3) tick();

        // Reset state
        chk("rst_cmd_ready", CMD_READY, 0);
        chk("rst_rsp_valid", RSP_VALID, 0);
        chk("rst_rsp_rdata", RSP_RDATA, 0);
        chk("rst_rsp_status", RSP_STATUS, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_cyc", CYC, 0);
        chk("rst_stb", STB, 0);
        chk("rst_we", WE, 0);
        chk("rst_sel", SEL, 0);
        chk("rst_addr", ADDR, 0);
        chk("rst_wdata", WDATA, 0);
        rstn = 1'b1;
        tick();
        chk("post_rst_cmd_ready", CMD_READY, 1);

        // Write, no stall, ACK one cycle after STB
        send_cmd(1'b1, 16'h0010, 8'hA5);
        chk("wr_req_cyc", CYC, 1);
        chk("wr_req_stb", STB, 1);
        chk("wr_req_sel", SEL, 1);
        chk("wr_req_we", WE, 1);
        chk("wr_req_addr", ADDR, 32'h3000_0010);
        chk("wr_req_wdata", WDATA, 8'hA5);
        chk("wr_req_cmd_ready", CMD_READY, 0);
        chk("wr_req_busy", BUSY, 1);
        tick();
        chk("wr_wait_cyc", CYC, 1);
        chk("wr_wait_stb", STB, 0);
        chk("wr_wait_we", WE, 1);
        chk("wr_wait_rsp_valid", RSP_VALID, 0);
        ACK = 1'b1;
        RDATA = 8'hFF;
        tick();
        ACK = 1'b0;
        chk("wr_done_cyc", CYC, 0);
        chk("wr_done_we", WE, 0);
        chk("wr_rsp_valid_hs3", RSP_VALID, 1);
        chk("wr_rsp_status", RSP_STATUS, 2'b00);
        chk("wr_rsp_rdata", RSP_RDATA, 8'h00);
        chk("wr_addr_hold", ADDR, 32'h3000_0010);
        rsp_take();
        chk("wr_after_rsp_valid", RSP_VALID, 0);
        chk("wr_after_cmd_ready", CMD_READY, 1);
        chk("wr_after_busy", BUSY, 0);

        // Read with 3 stall cycles
        send_cmd(1'b0, 16'h0042, 8'h00);
        STALL = 1'b1;
        chk("rd_stb_c1", STB, 1);
        chk("rd_we", WE, 0);
        chk("rd_addr", ADDR, 32'h3000_0042);
        tick();
        chk("rd_stb_c2", STB, 1);
        tick();
        chk("rd_stb_c3", STB, 1);
        tick();
        STALL = 1'b0;
        chk("rd_stb_c4", STB, 1);
        tick();
        chk("rd_stb_c5_low", STB, 0);
        chk("rd_wait_cyc", CYC, 1);
        ACK = 1'b1;
        RDATA = 8'h5C;
        tick();
        ACK = 1'b0;
        RDATA = 8'h00;
        chk("rd_rsp_valid", RSP_VALID, 1);
        chk("rd_rsp_rdata", RSP_RDATA, 8'h5C);
        chk("rd_rsp_status", RSP_STATUS, 2'b00);
        rsp_take();

        // ERR and ACK together in the REQ cycle
        send_cmd(1'b0, 16'h0001, 8'h00);
        ACK = 1'b1;
        ERR = 1'b1;
        RDATA = 8'h77;
        tick();
        ACK = 1'b0;
        ERR = 1'b0;
        RDATA = 8'h00;
        chk("err_cyc_fall", CYC, 0);
        chk("err_rsp_valid", RSP_VALID, 1);
        chk("err_rsp_status", RSP_STATUS, 2'b01);
        chk("err_rsp_rdata", RSP_RDATA, 8'h00);
        rsp_take();

        // Timeout with limit 8
        send_cmd(1'b1, 16'h0020, 8'h3C);
        cyc_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!CYC) break;
            cyc_cnt++;
            tick();
        end
        chk("tmo_cyc_cycles", cyc_cnt, 8);
        chk("tmo_rsp_valid", RSP_VALID, 1);
        chk("tmo_rsp_status", RSP_STATUS, 2'b10);
        chk("tmo_rsp_rdata", RSP_RDATA, 8'h00);
        rsp_take();
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("late_ack_rsp_valid", RSP_VALID, 0);
        chk("late_ack_busy", BUSY, 0);
        chk("late_ack_cyc", CYC, 0);
        tick();
        chk("late_ack_rsp_valid2", RSP_VALID, 0);

        // Back-pressure on the response
        send_cmd(1'b0, 16'h0005, 8'h00);
        tick();
        ACK = 1'b1;
        RDATA = 8'h9E;
        tick();
        ACK = 1'b0;
        RDATA = 8'h00;
        CMD_VALID = 1'b1;
        CMD_WE = 1'b1;
        CMD_ADDR = 16'hFFFF;
        CMD_WDATA = 8'h11;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", RSP_VALID, 1);
            chk("bp_rsp_rdata", RSP_RDATA, 8'h9E);
            chk("bp_rsp_status", RSP_STATUS, 2'b00);
            chk("bp_cmd_ready", CMD_READY, 0);
            chk("bp_cyc", CYC, 0);
            tick();
        end
        RSP_READY = 1'b1;
        tick();
        RSP_READY = 1'b0;
        chk("bp_idle_cmd_ready", CMD_READY, 1);
        chk("bp_idle_rsp_valid", RSP_VALID, 0);
        chk("bp_idle_cyc", CYC, 0);
        tick();
        CMD_VALID = 1'b0;
        chk("bp_next_cyc", CYC, 1);
        chk("bp_next_addr", ADDR, 32'h3000_FFFF);
        chk("bp_next_wdata", WDATA, 8'h11);

        // Reset while in WAIT
        tick();
        chk("rw_wait_cyc", CYC, 1);
        chk("rw_wait_stb", STB, 0);
        rstn = 1'b0;
        tick();
        chk("rw_rst_cyc", CYC, 0);
        chk("rw_rst_stb", STB, 0);
        chk("rw_rst_rsp_valid", RSP_VALID, 0);
        chk("rw_rst_cmd_ready", CMD_READY, 0);
        chk("rw_rst_busy", BUSY, 0);
        rstn = 1'b1;
        ACK = 1'b1;
        tick();
        ACK = 1'b0;
        chk("rw_post_cmd_ready", CMD_READY, 1);
        chk("rw_post_rsp_valid", RSP_VALID, 0);
        chk("rw_post_cyc", CYC, 0);
        tick();
        chk("rw_post_rsp_valid2", RSP_VALID, 0);
        chk("rw_post_busy", BUSY, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
